// File: rtl/enemy_pkg.sv
// Shared constants for the enemy sprite datapath: screen geometry, LFSR seed/taps, colours.
package enemy_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int SPRITE_DIM = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as state bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [2:0] BLACK = 3'b000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/enemy_datapath_if.sv
// Controller <-> enemy datapath bundle: strobes in, sprite state and VGA pixel writes out.
// writeEn is a one-cycle qualifier for x_out/y_out/colour_out; the adapter has no ready, so every strobed pixel is taken.
interface enemy_datapath_if;
    logic       en_reset;
    logic       loadX;
    logic       loadY;
    logic       load_colour;
    logic       load_black;
    logic       plot;
    logic       en_counter;
    logic       en_delay_counter;
    logic       reset_delay;
    logic [2:0] colour_in;

    logic [7:0] X;
    logic [6:0] Y;
    logic [3:0] cnt;
    logic [3:0] delay_cnt;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       writeEn;

    modport master (
        output en_reset, loadX, loadY, load_colour, load_black, plot,
               en_counter, en_delay_counter, reset_delay, colour_in,
        input  X, Y, cnt, delay_cnt, x_out, y_out, colour_out, writeEn
    );

    modport slave (
        input  en_reset, loadX, loadY, load_colour, load_black, plot,
               en_counter, en_delay_counter, reset_delay, colour_in,
        output X, Y, cnt, delay_cnt, x_out, y_out, colour_out, writeEn
    );
endinterface

// File: rtl/enemy_lfsr8.sv
// 8-bit Fibonacci LFSR used for enemy X spawn positions (only built with ENEMY_LFSR_EN).
module enemy_lfsr8
    import enemy_pkg::*;
(
    input  logic       CLOCK,
    input  logic       load_seed,
    input  logic       enable,
    output logic [7:0] state
);

    always_ff @(posedge CLOCK) begin
        if (load_seed)
            state <= LFSR_SEED;
        else if (enable)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/enemy_datapath.sv
// Enemy sprite datapath: position/colour registers, pixel and frame-delay counters, registered VGA writes.
// Optional macro ENEMY_LFSR_EN selects pseudo-random X spawns; otherwise X steps by a fixed stride.
module enemy_datapath
    import enemy_pkg::*;
#(
    parameter int X_INIT    = 76,
    parameter int Y_TOP     = 0,
    parameter int Y_BOTTOM  = 110,
    parameter int Y_STEP    = 1,
    parameter int X_MAX     = SCREEN_W - SPRITE_DIM,
    parameter int DELAY_DIV = 250000
) (
    input  logic              CLOCK,
    input  logic              resetn,
    enemy_datapath_if.slave   bus
);

    localparam int               PW      = $clog2(DELAY_DIV);
    localparam logic [PW-1:0]    PS_LAST = PW'(DELAY_DIV - 1);
    localparam int               X_STRIDE = 37;

    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [2:0]    colour_q;
    logic [3:0]    cnt_q;
    logic [3:0]    dly_q;
    logic [PW-1:0] prescale_q;
    logic [7:0]    x_pix_q;
    logic [6:0]    y_pix_q;
    logic [2:0]    colour_pix_q;
    logic          wr_q;

    logic          clear;
    logic [7:0]    x_spawn;
    logic [6:0]    y_next;

    // en_reset behaves like resetn for every register except the LFSR
    assign clear = !resetn || bus.en_reset;

`ifdef ENEMY_LFSR_EN
    logic [7:0] lfsr_q;

    enemy_lfsr8 u_lfsr (
        .CLOCK     (CLOCK),
        .load_seed (!resetn),
        .enable    (1'b1),
        .state     (lfsr_q)
    );

    always_comb begin
        x_spawn = lfsr_q;
        if (lfsr_q > 8'(X_MAX))
            x_spawn = lfsr_q - 8'd128;
    end
`else
    logic [8:0] x_sum;

    always_comb begin
        x_sum   = {1'b0, x_q} + 9'(X_STRIDE);
        x_spawn = x_sum[7:0];
        if (x_sum > 9'(X_MAX))
            x_spawn = 8'(x_sum - 9'(X_MAX + 1));
    end
`endif

    always_comb begin
        y_next = y_q + 7'(Y_STEP);
        if (y_q >= 7'(Y_BOTTOM))
            y_next = 7'(Y_TOP);
    end

    always_ff @(posedge CLOCK) begin
        if (clear) begin
            x_q      <= 8'(X_INIT);
            y_q      <= 7'(Y_TOP);
            colour_q <= BLACK;
            cnt_q    <= 4'd0;
        end else begin
            if (bus.loadX)
                x_q <= x_spawn;
            if (bus.loadY)
                y_q <= y_next;
            if (bus.load_black)
                colour_q <= BLACK;
            else if (bus.load_colour)
                colour_q <= bus.colour_in;
            if (bus.en_counter)
                cnt_q <= cnt_q + 4'd1;
        end
    end

    // Prescaler divides CLOCK down to one delay tick; delay_cnt saturates so the controller can sit in DONE
    always_ff @(posedge CLOCK) begin
        if (clear || !bus.reset_delay) begin
            prescale_q <= '0;
            dly_q      <= 4'd0;
        end else if (bus.en_delay_counter) begin
            if (prescale_q == PS_LAST) begin
                prescale_q <= '0;
                if (dly_q != 4'd15)
                    dly_q <= dly_q + 4'd1;
            end else begin
                prescale_q <= prescale_q + 1'b1;
            end
        end
    end

    // One-stage pixel pipeline: the write for cnt=k lands the cycle after the plot cycle
    always_ff @(posedge CLOCK) begin
        if (clear) begin
            x_pix_q      <= 8'd0;
            y_pix_q      <= 7'd0;
            colour_pix_q <= BLACK;
            wr_q         <= 1'b0;
        end else begin
            x_pix_q      <= x_q + {6'd0, cnt_q[1:0]};
            y_pix_q      <= y_q + {5'd0, cnt_q[3:2]};
            colour_pix_q <= colour_q;
            wr_q         <= bus.plot;
        end
    end

    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.cnt        = cnt_q;
    assign bus.delay_cnt  = dly_q;
    assign bus.x_out      = x_pix_q;
    assign bus.y_out      = y_pix_q;
    assign bus.colour_out = colour_pix_q;
    assign bus.writeEn    = wr_q;

endmodule

// File: tb/tb_enemy_datapath.sv
// Directed self-checking bench for enemy_datapath (DELAY_DIV=4); covers both ENEMY_LFSR_EN builds.
module tb_enemy_datapath;

    // ---------------- clock / reset ----------------
    logic CLOCK = 1'b0;
    logic resetn = 1'b0;
    always #5 CLOCK = ~CLOCK;

    enemy_datapath_if bus ();

    enemy_datapath #(.DELAY_DIV(4)) dut (
        .CLOCK  (CLOCK),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected pixel writes, packed {x[7:0], y[6:0], colour[2:0]}
    logic [17:0] exp_q[$];

`ifdef ENEMY_LFSR_EN
    logic [7:0] lfsr_m;
    always @(posedge CLOCK) begin
        if (!resetn)
            lfsr_m <= 8'hA5;
        else
            lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif

    // Expected X after loadX: the hand-computed stride value, or the LFSR model's spawn
    function automatic logic [7:0] exp_spawn(input logic [7:0] hand);
`ifdef ENEMY_LFSR_EN
        return (lfsr_m <= 8'd156) ? lfsr_m : lfsr_m - 8'd128;
`else
        return hand;
`endif
    endfunction

    // ---------------- scoreboard / checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.en_reset         = 1'b0;
        bus.loadX            = 1'b0;
        bus.loadY            = 1'b0;
        bus.load_colour      = 1'b0;
        bus.load_black       = 1'b0;
        bus.plot             = 1'b0;
        bus.en_counter       = 1'b0;
        bus.en_delay_counter = 1'b0;
        bus.reset_delay      = 1'b0;
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic draw16(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] col);
        logic [17:0] e;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({x0 + 8'(i % 4), y0 + 7'(i / 4), col});
            bus.plot       = 1'b1;
            bus.en_counter = 1'b1;
            step();
            e = exp_q.pop_front();
            check($sformatf("pix%0d", i),
                  {13'd0, bus.writeEn, bus.x_out, bus.y_out, bus.colour_out},
                  {13'd0, 1'b1, e});
        end
        bus.plot       = 1'b0;
        bus.en_counter = 1'b0;
        step();
        check("wr_after_draw", bus.writeEn, 0);
        check("cnt_wrap", bus.cnt, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] ex;

    initial begin
        idle();
        bus.colour_in = 3'b000;
        resetn = 1'b0;
        repeat (3) step();
        check("rst_X", bus.X, 76);
        check("rst_Y", bus.Y, 0);
        check("rst_cnt", bus.cnt, 0);
        check("rst_delay", bus.delay_cnt, 0);
        check("rst_wr", bus.writeEn, 0);
        check("rst_xy_out", {bus.x_out, bus.y_out}, 0);
        check("rst_col_out", bus.colour_out, 0);
        resetn = 1'b1;

        // latch red and draw the sprite at the spawn position
        bus.load_colour = 1'b1;
        bus.colour_in   = 3'b100;
        step();
        bus.load_colour = 1'b0;
        step();
        check("colour_latched", bus.colour_out, 4);
        draw16(8'd76, 7'd0, 3'b100);

        // move to Y=5; load_black wins over a simultaneous load_colour
        bus.loadY = 1'b1;
        repeat (5) step();
        bus.loadY = 1'b0;
        check("Y_after_5", bus.Y, 5);
        bus.load_black  = 1'b1;
        bus.load_colour = 1'b1;
        bus.colour_in   = 3'b111;
        step();
        bus.load_black  = 1'b0;
        bus.load_colour = 1'b0;
        draw16(8'd76, 7'd5, 3'b000);

        // frame delay: 4 CLOCKs per tick, saturate at 15
        bus.reset_delay      = 1'b1;
        bus.en_delay_counter = 1'b1;
        repeat (59) step();
        check("delay_59", bus.delay_cnt, 14);
        step();
        check("delay_60", bus.delay_cnt, 15);
        repeat (8) step();
        check("delay_sat", bus.delay_cnt, 15);
        bus.reset_delay = 1'b0;
        step();
        check("delay_clear", bus.delay_cnt, 0);
        bus.en_delay_counter = 1'b0;

        // en_reset overrides concurrent strobes
        bus.en_reset   = 1'b1;
        bus.loadY      = 1'b1;
        bus.plot       = 1'b1;
        bus.en_counter = 1'b1;
        step();
        idle();
        check("enrst_X", bus.X, 76);
        check("enrst_Y", bus.Y, 0);
        check("enrst_cnt", bus.cnt, 0);
        check("enrst_wr", bus.writeEn, 0);

        // spawn sequence 76 -> 113 -> 150 -> 30 (wrap past X_MAX)
        bus.loadX = 1'b1;
        ex = exp_spawn(8'd113);
        step();
        check("loadX_1", bus.X, ex);
        ex = exp_spawn(8'd150);
        step();
        check("loadX_2", bus.X, ex);
        ex = exp_spawn(8'd30);
        step();
        check("loadX_wrap", bus.X, ex);
        bus.loadX = 1'b0;

        // walk Y to the bottom row, then wrap together with an X respawn
        bus.en_reset = 1'b1;
        step();
        bus.en_reset = 1'b0;
        bus.loadY = 1'b1;
        repeat (109) step();
        check("Y_109", bus.Y, 109);
        step();
        check("Y_bottom", bus.Y, 110);
        bus.loadX = 1'b1;
        ex = exp_spawn(8'd113);
        step();
        idle();
        check("Y_wrap", bus.Y, 0);
        check("X_with_wrap", bus.X, ex);
        check("X_le_max", bus.X <= 8'd156, 1);

        // resetn mid-draw at cnt=7
        bus.loadY = 1'b1;
        repeat (3) step();
        bus.loadY = 1'b0;
        bus.plot       = 1'b1;
        bus.en_counter = 1'b1;
        repeat (7) step();
        check("mid_cnt7", bus.cnt, 7);
        check("mid_wr", bus.writeEn, 1);
        resetn = 1'b0;
        step();
        check("mid_rst_cnt", bus.cnt, 0);
        check("mid_rst_wr", bus.writeEn, 0);
        check("mid_rst_X", bus.X, 76);
        check("mid_rst_Y", bus.Y, 0);
        resetn = 1'b1;
        idle();
        step();
        check("post_rst_wr", bus.writeEn, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
